// File: rtl/snowv_fsm_if.sv
// T1/T2 tap stream from the LFSR and the registered output-word stream of the
// SNOW-V FSM engine, bundled as one handshake interface.
interface snowv_fsm_if #(
    parameter int WIDTH = 128
);
    logic             t_valid;
    logic             t_ready;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;
    logic             z_valid;
    logic             z_ready;
    logic [WIDTH-1:0] z_data;
    logic             z_init;

    // master: LFSR + keystream consumer side; slave: the FSM engine
    modport master (output t_valid, t1, t2, z_ready,
                    input  t_ready, z_valid, z_data, z_init);
    modport slave  (input  t_valid, t1, t2, z_ready,
                    output t_ready, z_valid, z_data, z_init);
endinterface

// File: rtl/snowv_fsm_engine.sv
// SNOW-V FSM engine: R1/R2/R3 update per accepted tap pair, init phase with key
// mixing into R1, then keystream. Optional 64-bit word counter: SNOWV_FSM_WORDCNT_EN.
module snowv_fsm_engine #(
    parameter int LANE_W     = 32,
    parameter int WIDTH      = 128,
    parameter int INIT_STEPS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         flush,
    input  logic [255:0] key,
    snowv_fsm_if.slave   bus,
    output logic         busy
`ifdef SNOWV_FSM_WORDCNT_EN
    ,
    output logic [63:0]  word_cnt
`endif
);

    if (WIDTH != 128) begin : g_bad_width
        $error("snowv_fsm_engine: WIDTH must be 128");
    end
    if (LANE_W != 8 && LANE_W != 16 && LANE_W != 32 && LANE_W != 64) begin : g_bad_lane
        $error("snowv_fsm_engine: LANE_W must be 8, 16, 32 or 64");
    end
    if (INIT_STEPS < 2 || INIT_STEPS > 255) begin : g_bad_steps
        $error("snowv_fsm_engine: INIT_STEPS must be in 2..255");
    end

    localparam int         LANES     = WIDTH / LANE_W;
    localparam logic [7:0] LAST_STEP = 8'(INIT_STEPS - 1);
    localparam logic [7:0] PRE_STEP  = 8'(INIT_STEPS - 2);

    // AES S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[8*(255 - int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i lives at bits [8i+7:8i]; column c holds bytes 4c..4c+3 (row = i%4).
    function automatic logic [127:0] aes_round(input logic [127:0] s);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) sb[i] = sub_byte(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] sigma(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int j = 0; j < 16; j++) o[8*j +: 8] = x[8*(4*(j % 4) + j / 4) +: 8];
        return o;
    endfunction

    // Independent carry chains: no carry crosses a lane boundary.
    function automatic logic [127:0] lane_add(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] o;
        o = '0;
        for (int l = 0; l < LANES; l++)
            o[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
        return o;
    endfunction

    state_t       state;
    logic [7:0]   step_cnt;
    logic [255:0] key_q;
    logic [127:0] r1, r2, r3;
    logic [127:0] z_data, z_next;
    logic [127:0] r1_next, r2_next, r3_next;
    logic         z_valid, z_init;
    logic         t_ready, fire;

    assign t_ready     = (state == INIT || state == RUN) && (!z_valid || bus.z_ready);
    assign fire        = bus.t_valid && t_ready;
    assign busy        = (state != IDLE);
    assign bus.t_ready = t_ready;
    assign bus.z_valid = z_valid;
    assign bus.z_data  = z_data;
    assign bus.z_init  = z_init;

    always_comb begin
        // NOTE: every output of this block is assigned first so no latch is inferred
        z_next  = lane_add(bus.t1, r1) ^ r2;
        r1_next = sigma(lane_add(r3 ^ bus.t2, r2));
        r2_next = aes_round(r1);
        r3_next = aes_round(r2);
        if (state == INIT && step_cnt == PRE_STEP)
            r1_next = r1_next ^ key_q[127:0];
        else if (state == INIT && step_cnt == LAST_STEP)
            r1_next = r1_next ^ key_q[255:128];
    end

    // NOTE: sequential state uses non-blocking assignments only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_cnt <= '0;
            key_q    <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            z_data   <= '0;
            z_valid  <= 1'b0;
            z_init   <= 1'b0;
`ifdef SNOWV_FSM_WORDCNT_EN
            word_cnt <= '0;
`endif
        end else if (flush) begin
            // key_q is deliberately kept across a flush
            state    <= IDLE;
            step_cnt <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            z_data   <= '0;
            z_valid  <= 1'b0;
            z_init   <= 1'b0;
`ifdef SNOWV_FSM_WORDCNT_EN
            word_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    key_q    <= key;
                    r1       <= '0;
                    r2       <= '0;
                    r3       <= '0;
                    step_cnt <= '0;
                    state    <= INIT;
`ifdef SNOWV_FSM_WORDCNT_EN
                    word_cnt <= '0;
`endif
                end
                INIT: if (fire) begin
                    if (step_cnt == LAST_STEP) begin
                        state    <= RUN;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                RUN: ;
                default: state <= IDLE;
            endcase

            if (fire) begin
                z_data  <= z_next;
                z_init  <= (state == INIT);
                z_valid <= 1'b1;
                r1      <= r1_next;
                r2      <= r2_next;
                r3      <= r3_next;
`ifdef SNOWV_FSM_WORDCNT_EN
                if (state == RUN) word_cnt <= word_cnt + 64'd1;
`endif
            end else if (bus.z_ready) begin
                z_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snowv_fsm_engine.sv
// Self-checking bench for snowv_fsm_engine: cycle model of R1/R2/R3 with its own
// GF(2^8) S-box, and a scoreboard of expected output words.
module tb_snowv_fsm_engine;

    localparam int WIDTH      = 128;
    localparam int LANE_W     = 32;
    localparam int INIT_STEPS = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [255:0] key   = '0;
    logic         busy;
`ifdef SNOWV_FSM_WORDCNT_EN
    logic [63:0]  word_cnt;
`endif

    snowv_fsm_if #(.WIDTH(WIDTH)) bus ();

    snowv_fsm_engine #(
        .LANE_W    (LANE_W),
        .WIDTH     (WIDTH),
        .INIT_STEPS(INIT_STEPS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .key     (key),
        .bus     (bus),
        .busy    (busy)
`ifdef SNOWV_FSM_WORDCNT_EN
        ,
        .word_cnt(word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic         zi;
        logic [127:0] zd;
    } out_t;

    // ---------------- reference model ----------------
    logic [7:0]   sbox_t [256];
    int           m_st, m_cnt;
    logic [255:0] m_kq;
    logic [127:0] m_r1, m_r2, m_r3, m_zd;
    logic         m_zv, m_zi;
    logic [63:0]  m_wc;
    out_t         sb_q [$];
    out_t         obs_a [$];
    out_t         exp_a [$];
    int           rec_mode = 0;
    int           ridx = 0;
    int           sig [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] m_aes(input logic [127:0] s);
        logic [7:0]   t [4][4];
        logic [7:0]   acc;
        logic [127:0] o;
        int           coef [4];
        coef = '{2, 3, 1, 1};
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = sbox_t[s[8*(4*((c + r) % 4) + r) +: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(8'(coef[(k - r + 4) % 4]), t[k][c]);
                o[8*(4*c + r) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] m_sigma(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int j = 0; j < 16; j++) o[8*j +: 8] = x[8*sig[j] +: 8];
        return o;
    endfunction

    function automatic logic [127:0] m_lane_add(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] o;
        logic [63:0]  mask, s;
        o = '0;
        mask = (LANE_W == 64) ? '1 : ((64'd1 << LANE_W) - 64'd1);
        for (int l = 0; l < WIDTH / LANE_W; l++) begin
            s = (64'(a >> (l * LANE_W)) + 64'(b >> (l * LANE_W))) & mask;
            o = o | (128'(s) << (l * LANE_W));
        end
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_kq = '0;
        m_r1 = '0; m_r2 = '0; m_r3 = '0; m_zd = '0;
        m_zv = 1'b0; m_zi = 1'b0; m_wc = '0;
        sb_q.delete();
    endtask

    // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
    task automatic step();
        logic         tr, fire;
        int           n_st, n_cnt;
        logic [255:0] n_kq;
        logic [127:0] n_r1, n_r2, n_r3, n_zd;
        logic         n_zv, n_zi;
        logic [63:0]  n_wc;
        out_t         e;
        @(negedge clk);
        tr = (m_st != 0) && (!m_zv || bus.z_ready);
        check("t_ready", 256'(bus.t_ready), 256'(tr));
        check("z_valid", 256'(bus.z_valid), 256'(m_zv));
        check("z_data",  256'(bus.z_data),  256'(m_zd));
        check("z_init",  256'(bus.z_init),  256'(m_zi));
        check("busy",    256'(busy),        256'(m_st != 0));
`ifdef SNOWV_FSM_WORDCNT_EN
        check("word_cnt", 256'(word_cnt), 256'(m_wc));
`endif
        if (bus.z_valid && bus.z_ready) begin
            check("sb_depth", 256'(sb_q.size() > 0), 256'(1));
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_z_data", 256'(bus.z_data), 256'(e.zd));
                check("sb_z_init", 256'(bus.z_init), 256'(e.zi));
                if (rec_mode == 1) begin
                    obs_a.push_back({bus.z_init, bus.z_data});
                    exp_a.push_back(e);
                end
                if (rec_mode == 2 && ridx < exp_a.size()) begin
                    check("replay", 256'(bus.z_data), 256'(exp_a[ridx].zd));
                    ridx++;
                end
            end
        end

        fire = bus.t_valid && tr;
        n_st = m_st; n_cnt = m_cnt; n_kq = m_kq;
        n_r1 = m_r1; n_r2 = m_r2; n_r3 = m_r3;
        n_zd = m_zd; n_zv = m_zv; n_zi = m_zi; n_wc = m_wc;
        if (flush) begin
            n_st = 0; n_cnt = 0; n_r1 = '0; n_r2 = '0; n_r3 = '0;
            n_zd = '0; n_zv = 1'b0; n_zi = 1'b0; n_wc = '0;
        end else begin
            if (m_st == 0 && start) begin
                n_kq = key; n_r1 = '0; n_r2 = '0; n_r3 = '0;
                n_wc = '0; n_st = 1; n_cnt = 0;
            end
            if (fire) begin
                n_zd = m_lane_add(bus.t1, m_r1) ^ m_r2;
                n_zi = (m_st == 1);
                n_zv = 1'b1;
                n_r1 = m_sigma(m_lane_add(m_r3 ^ bus.t2, m_r2));
                if (m_st == 1 && m_cnt == INIT_STEPS - 2) n_r1 = n_r1 ^ m_kq[127:0];
                if (m_st == 1 && m_cnt == INIT_STEPS - 1) n_r1 = n_r1 ^ m_kq[255:128];
                n_r2 = m_aes(m_r1);
                n_r3 = m_aes(m_r2);
                if (m_st == 1) begin
                    if (m_cnt == INIT_STEPS - 1) begin
                        n_st = 2; n_cnt = 0;
                    end else begin
                        n_cnt = m_cnt + 1;
                    end
                end else begin
                    n_wc = m_wc + 64'd1;
                end
            end else if (bus.z_ready) begin
                n_zv = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_st = n_st; m_cnt = n_cnt; m_kq = n_kq;
            m_r1 = n_r1; m_r2 = n_r2; m_r3 = n_r3;
            m_zd = n_zd; m_zv = n_zv; m_zi = n_zi; m_wc = n_wc;
            if (fire && !flush) sb_q.push_back({n_zi, n_zd});
        end
    endtask

    task automatic pulse_start(input logic [255:0] k);
        key   = k;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n_init;
        logic [31:0] lane_pat;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        model_reset();

        bus.t_valid = 1'b0;
        bus.z_ready = 1'b1;
        bus.t1      = '0;
        bus.t2      = '0;

        // Reset, then zero key and zero taps: capture the reference sequence
        repeat (3) step();
        rst_n = 1'b1;
        step();
        bus.t_valid = 1'b1;
        rec_mode = 1;
        pulse_start('0);
        repeat (20) step();
        rec_mode = 0;

        check("a_pops", 256'(obs_a.size() >= 17), 256'(1));
        if (obs_a.size() >= 17) begin
            check("first_z_data",  256'(obs_a[0].zd), 256'(0));
            check("first_z_init",  256'(obs_a[0].zi), 256'(1));
            check("second_z_data", 256'(obs_a[1].zd), 256'({16{8'h63}}));
            n_init = 0;
            foreach (obs_a[i]) if (obs_a[i].zi) n_init++;
            check("init_count", 256'(n_init), 256'(INIT_STEPS));
            check("first_run_z_init", 256'(obs_a[INIT_STEPS].zi), 256'(0));
        end

        // All-ones key with lane-boundary tap patterns and random handshakes
        flush = 1'b1;
        step();
        flush = 1'b0;
        pulse_start('1);
        for (int i = 0; i < 70; i++) begin
            case (i % 4)
                0: lane_pat = 32'hffff_ffff;
                1: lane_pat = 32'h0000_0001;
                2: lane_pat = 32'h8000_0000;
                default: lane_pat = $urandom;
            endcase
            bus.t1      = (i % 4 == 3) ? {$urandom, $urandom, $urandom, $urandom} : {4{lane_pat}};
            bus.t2      = {$urandom, $urandom, $urandom, $urandom};
            bus.t_valid = ($urandom_range(0, 3) != 0);
            bus.z_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Backpressure: output held, no fires, then one fire per cycle
        bus.t_valid = 1'b1;
        bus.z_ready = 1'b1;
        step();
        bus.z_ready = 1'b0;
        repeat (5) step();
        bus.z_ready = 1'b1;
        repeat (5) step();

        // Flush mid-INIT after step 7, then replay the zero-key sequence
        bus.t1 = '0;
        bus.t2 = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        pulse_start('0);
        repeat (8) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        rec_mode = 2;
        ridx = 0;
        pulse_start('0);
        repeat (20) step();
        rec_mode = 0;
        check("replay_len", 256'(ridx), 256'(exp_a.size()));

        // Asynchronous reset between clock edges while in RUN
        bus.t1 = {4{32'h0123_4567}};
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_z_valid", 256'(bus.z_valid), 256'(0));
        check("arst_z_data",  256'(bus.z_data),  256'(0));
        check("arst_z_init",  256'(bus.z_init),  256'(0));
        check("arst_t_ready", 256'(bus.t_ready), 256'(0));
        check("arst_busy",    256'(busy),        256'(0));
`ifdef SNOWV_FSM_WORDCNT_EN
        check("arst_word_cnt", 256'(word_cnt), 256'(0));
`endif
        model_reset();
        rst_n = 1'b1;
        step();
        pulse_start({8{32'hdead_beef}});
        repeat (25) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
